// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: computes the 64-bit result at issue, then holds it
// in staging registers while busy counts down the architectural latency before committing HI/LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        md_stall
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [31:0]   hi_q, lo_q, hi_nx, lo_nx;
  logic [63:0]   stage, stage_nx;
  logic          stage_wr, stage_wr_nx;

  logic        long_op, is_div, sgn_mul, sgn_div;
  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign long_op = start & ~md_op[2];
  assign is_div  = md_op[1];
  assign sgn_mul = (md_op == 3'd0);
  assign sgn_div = (md_op == 3'd2);

  // One 64x64 multiplier covers both forms; sign extension selects MULT vs MULTU.
  assign mul_a   = {{32{sgn_mul & rs_val[31]}}, rs_val};
  assign mul_b   = {{32{sgn_mul & rt_val[31]}}, rt_val};
  assign product = mul_a * mul_b;

  // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg = sgn_div & rs_val[31];
  assign b_neg = sgn_div & rt_val[31];
  assign a_mag = a_neg ? -rs_val : rs_val;
  assign b_mag = b_neg ? -rt_val : rt_val;
  assign q_mag = (b_mag != 32'd0) ? a_mag / b_mag : 32'd0;
  assign r_mag = (b_mag != 32'd0) ? a_mag % b_mag : 32'd0;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    hi_nx       = hi_q;
    lo_nx       = lo_q;
    stage_nx    = stage;
    stage_wr_nx = stage_wr;
    case (state)
      IDLE: begin
        if (long_op) begin
          stage_nx    = is_div ? {rem, quo} : product;
          stage_wr_nx = ~(is_div & (rt_val == 32'd0));
          count_nx    = is_div ? DIV_LAST : MULT_LAST;
          state_nx    = RUN;
        end else if (start && md_op == 3'd4) begin
          hi_nx = rs_val;
        end else if (start && md_op == 3'd5) begin
          lo_nx = rs_val;
        end
      end
      RUN: begin
        if (count == '0) begin
          if (stage_wr) begin
            hi_nx = stage[63:32];
            lo_nx = stage[31:0];
          end
          state_nx = IDLE;
        end else begin
          count_nx = count - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      stage    <= '0;
      stage_wr <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      hi_q     <= hi_nx;
      lo_q     <= lo_nx;
      stage    <= stage_nx;
      stage_wr <= stage_wr_nx;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state == RUN);
  assign md_stall = d_is_md & (busy | long_op);

  always_comb begin
    md_rdata = 32'd0;
    if (start && md_op == 3'd6) md_rdata = hi_q;
    else if (start && md_op == 3'd7) md_rdata = lo_q;
  end
endmodule
